// File: rtl/periph_timer_pkg.sv
// Shared types, register offsets and CTRL bit positions for the memory-mapped timer.
package periph_timer_pkg;

  typedef enum logic [2:0] {
    MEM_LOAD = 3'd0,
    STORE_B  = 3'd1,
    STORE_H  = 3'd2,
    STORE_W  = 3'd3,
    STORE_D  = 3'd4
  } mem_store_type_t;

  typedef enum logic [7:0] {
    OFF_CTRL    = 8'h00,
    OFF_COUNT   = 8'h08,
    OFF_COMPARE = 8'h10,
    OFF_STATUS  = 8'h18
  } periph_timer_offset_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } bus_state_e;

  localparam int unsigned CTRL_EN_BIT          = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT      = 1;
  localparam int unsigned CTRL_AUTO_RELOAD_BIT = 2;
  localparam int unsigned CTRL_PRESCALE_LSB    = 8;
  localparam int unsigned CTRL_PRESCALE_MSB    = 15;

  // Byte enables for a store of the given width at lane addr; zero when misaligned.
  function automatic logic [7:0] store_lane_mask(input mem_store_type_t st, input logic [2:0] addr);
    logic [7:0] m;
    m = '0;
    case (st)
      STORE_B: m = 8'h01 << addr;
      STORE_H: m = addr[0]        ? 8'h00 : (8'h03 << addr);
      STORE_W: m = (addr[1:0] != 2'b00) ? 8'h00 : (8'h0F << addr);
      STORE_D: m = (addr != 3'b000) ? 8'h00 : 8'hFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/periph_timer_counter.sv
// Prescaler, 64-bit COUNT, COMPARE match and pending flag, driven by bus write strobes.
module periph_timer_counter
  import periph_timer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_wr_ctrl,
  input  logic        i_wr_count,
  input  logic        i_wr_compare,
  input  logic        i_clr_pending,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_ctrl,
  output logic [63:0] o_count,
  output logic [63:0] o_compare,
  output logic        o_pending,
  output logic        o_irq_next
);

  logic        r_en, r_irq_en, r_auto_reload, r_pending;
  logic [7:0]  r_prescale, r_pre;
  logic [63:0] r_count, r_compare;
  logic        w_tick, w_match, w_pending_next, w_irq_en_next;

  assign w_tick         = r_en && (r_pre == r_prescale);
  assign w_match        = w_tick && (r_count == r_compare);
  // A new match overrides a same-cycle write-1-to-clear.
  assign w_pending_next = (r_pending && !i_clr_pending) || w_match;
  assign w_irq_en_next  = i_wr_ctrl ? i_wdata[CTRL_IRQ_EN_BIT] : r_irq_en;
  assign o_irq_next     = w_pending_next && w_irq_en_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_en          <= 1'b0;
      r_irq_en      <= 1'b0;
      r_auto_reload <= 1'b0;
      r_prescale    <= '0;
      r_pre         <= '0;
      r_count       <= '0;
      r_compare     <= '1;
      r_pending     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (i_wr_ctrl) begin
        r_en          <= i_wdata[CTRL_EN_BIT];
        r_irq_en      <= i_wdata[CTRL_IRQ_EN_BIT];
        r_auto_reload <= i_wdata[CTRL_AUTO_RELOAD_BIT];
        r_prescale    <= i_wdata[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
      end
      if (i_wr_ctrl && !i_wdata[CTRL_EN_BIT]) r_pre <= '0;
      else if (w_tick)                        r_pre <= '0;
      else if (r_en)                          r_pre <= r_pre + 8'd1;
      if (i_wr_count)                     r_count <= i_wdata;
      else if (w_match && r_auto_reload)  r_count <= '0;
      else if (w_tick)                    r_count <= r_count + 64'd1;
      if (i_wr_compare) r_compare <= i_wdata;
    end
  end

  always_comb begin
    o_ctrl = '0;
    o_ctrl[CTRL_EN_BIT]          = r_en;
    o_ctrl[CTRL_IRQ_EN_BIT]      = r_irq_en;
    o_ctrl[CTRL_AUTO_RELOAD_BIT] = r_auto_reload;
    o_ctrl[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = r_prescale;
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_pending = r_pending;

endmodule

// File: rtl/periph_timer.sv
// Timer peripheral top: address decode, bus handshake FSM, store merge, read mux, irq register.
module periph_timer
  import periph_timer_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h2000_0000,
  parameter int unsigned WINDOW_BITS = 6,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     d_addr,
  input  logic [63:0]     d_wdata,
  input  mem_store_type_t d_store_type,
  input  logic            d_valid,
  output logic [63:0]     d_rdata,
  output logic            d_ready,
  output logic            irq
);

  localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  bus_state_e              r_state;
  logic                    r_ready, r_irq;
  logic [WAIT_W-1:0]       r_wait;
  logic                    w_sel, w_commit, w_irq_next, w_pending;
  logic                    w_is_ctrl, w_is_count, w_is_compare, w_is_status;
  logic [WINDOW_BITS-1:0]  w_off;
  logic [7:0]              w_mask;
  logic [63:0]             w_bits, w_rdval, w_merged, w_ctrl, w_count, w_compare;

  assign w_sel        = (d_addr[63:WINDOW_BITS] == BASE_ADDR[63:WINDOW_BITS]);
  assign w_off        = {d_addr[WINDOW_BITS-1:3], 3'b000};
  assign w_is_ctrl    = (w_off == WINDOW_BITS'(OFF_CTRL));
  assign w_is_count   = (w_off == WINDOW_BITS'(OFF_COUNT));
  assign w_is_compare = (w_off == WINDOW_BITS'(OFF_COMPARE));
  assign w_is_status  = (w_off == WINDOW_BITS'(OFF_STATUS));
  assign w_mask       = store_lane_mask(d_store_type, d_addr[2:0]);

  always_comb begin
    w_bits = '0;
    for (int unsigned i = 0; i < 8; i++) w_bits[8*i +: 8] = {8{w_mask[i]}};
  end

  always_comb begin
    w_rdval = '0;
    if (w_is_ctrl)         w_rdval = w_ctrl;
    else if (w_is_count)   w_rdval = w_count;
    else if (w_is_compare) w_rdval = w_compare;
    else if (w_is_status)  w_rdval = {63'd0, w_pending};
  end

  // Request fields are held by the core, so the store is merged straight from the bus in RESP.
  assign w_merged = (w_rdval & ~w_bits) | (d_wdata & w_bits);
  assign w_commit = (r_state == ST_RESP) && (w_mask != 8'h00);

  periph_timer_counter u_counter (
    .clock         (clock),
    .reset         (reset),
    .i_wr_ctrl     (w_commit && w_is_ctrl),
    .i_wr_count    (w_commit && w_is_count),
    .i_wr_compare  (w_commit && w_is_compare),
    .i_clr_pending (w_commit && w_is_status && w_mask[0] && d_wdata[0]),
    .i_wdata       (w_merged),
    .o_ctrl        (w_ctrl),
    .o_count       (w_count),
    .o_compare     (w_compare),
    .o_pending     (w_pending),
    .o_irq_next    (w_irq_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_wait  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_irq   <= w_irq_next;
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (d_valid && w_sel) begin
            r_wait <= '0;
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_RESP;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_state <= ST_RESP;
            r_ready <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign d_ready = r_ready;
  assign d_rdata = r_ready ? w_rdval : '0;
  assign irq     = r_irq;

endmodule
